// File: rtl/proj_mux_pkg.sv
// Shared types and register map for the multi-project pad-select controller.
package proj_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_SWITCH  = 2'd2,
      ST_RELEASE = 2'd3
   } mux_state_e;

   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_SETTINGS = 2'd2;
   localparam logic [1:0] REG_SOFT_RST = 2'd3;

   localparam int STATUS_BUSY_BIT = 8;
   localparam int STATUS_ERR_BIT  = 9;

endpackage

// File: rtl/proj_mux_ctrl.sv
// Project-select controller: Wishbone register file, safe switch sequencer
// and the shared pad mux for NPROJ hosted designs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | selection stable, waiting for a pending request
//   DRAIN   | all project resets asserted, pads tri-stated, hold timer
//   SWITCH  | active <= pend_sel, pending cleared, release prepared
//   RELEASE | chosen project out of reset, pads enabled, done irq
module proj_mux_ctrl
   import proj_mux_pkg::*;
#(
   parameter int          NPROJ     = 5,
   parameter int          IO_W      = 33,
   parameter int          RST_HOLD  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   input  logic [NPROJ*IO_W-1:0]   proj_do,
   input  logic [NPROJ*IO_W-1:0]   proj_oeb,
   output logic [IO_W-1:0]         io_out,
   output logic [IO_W-1:0]         io_oeb,
   output logic [NPROJ-1:0]        rst_n_o,
   output logic [31:0]             custom_settings,
   output logic [2:0]              irq
);

   localparam logic [7:0] NONE_SEL = 8'(NPROJ);
   localparam int         CNT_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   mux_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       active_q, active_d;
   logic [7:0]       pend_sel_q, pend_sel_d;
   logic             pend_v_q, pend_v_d;
   logic [7:0]       req_q, req_d;
   logic             err_q, err_d;
   logic [31:0]      settings_q, settings_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic [NPROJ-1:0] rst_n_q, rst_n_d;
   logic             out_en_q, out_en_d;
   logic             done_q, done_d;
   logic             inval_q, inval_d;

   logic        wb_req, hit, busy;
   logic [31:0] rdata;
   logic        unused_adr;

   assign unused_adr = ^wbs_adr_i[1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      active_d   = active_q;
      pend_sel_d = pend_sel_q;
      pend_v_d   = pend_v_q;
      req_d      = req_q;
      err_d      = err_q;
      settings_d = settings_q;
      rst_n_d    = rst_n_q;
      out_en_d   = out_en_q;
      done_d     = 1'b0;
      inval_d    = 1'b0;

      wb_req = wbs_cyc_i & wbs_stb_i & ~ack_q;
      hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
      busy   = (state_q != ST_IDLE) | pend_v_q;

      rdata = '0;
      unique case (wbs_adr_i[3:2])
         REG_CTRL:     rdata = {24'd0, req_q};
         REG_STATUS:   rdata = {22'd0, err_q, busy, active_q};
         REG_SETTINGS: rdata = settings_q;
         default:      rdata = '0;
      endcase

      ack_d = wb_req;
      dat_d = (wb_req & ~wbs_we_i & hit) ? rdata : 32'd0;

      unique case (state_q)
         ST_IDLE: begin
            if (pend_v_q) begin
               state_d  = ST_DRAIN;
               cnt_d    = CNT_W'(RST_HOLD - 1);
               rst_n_d  = '0;
               out_en_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) state_d = ST_SWITCH;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_SWITCH: begin
            active_d = pend_sel_q;
            pend_v_d = 1'b0;
            for (int k = 0; k < NPROJ; k++) rst_n_d[k] = (pend_sel_q == 8'(k));
            out_en_d = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_RELEASE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Bus writes are evaluated after the FSM so a request landing on the
      // SWITCH cycle survives the pending clear and runs its own sequence.
      if (wb_req & wbs_we_i & hit) begin
         unique case (wbs_adr_i[3:2])
            REG_CTRL: begin
               if (wbs_dat_i[7:0] <= NONE_SEL) begin
                  pend_sel_d = wbs_dat_i[7:0];
                  pend_v_d   = 1'b1;
                  req_d      = wbs_dat_i[7:0];
               end else begin
                  err_d   = 1'b1;
                  inval_d = 1'b1;
               end
            end
            REG_STATUS: begin
               if (wbs_dat_i[STATUS_ERR_BIT]) err_d = 1'b0;
            end
            REG_SETTINGS: begin
               for (int b = 0; b < 4; b++)
                  if (wbs_sel_i[b]) settings_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end
            default: begin
               pend_sel_d = active_q;
               pend_v_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         active_q   <= NONE_SEL;
         pend_sel_q <= NONE_SEL;
         pend_v_q   <= 1'b0;
         req_q      <= NONE_SEL;
         err_q      <= 1'b0;
         settings_q <= '0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         rst_n_q    <= '0;
         out_en_q   <= 1'b0;
         done_q     <= 1'b0;
         inval_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         active_q   <= active_d;
         pend_sel_q <= pend_sel_d;
         pend_v_q   <= pend_v_d;
         req_q      <= req_d;
         err_q      <= err_d;
         settings_q <= settings_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         rst_n_q    <= rst_n_d;
         out_en_q   <= out_en_d;
         done_q     <= done_d;
         inval_q    <= inval_d;
      end
   end

   // "none" (active == NPROJ) matches no slice, so pads stay inputs.
   always_comb begin
      io_out = '0;
      io_oeb = '1;
      if (out_en_q) begin
         for (int k = 0; k < NPROJ; k++) begin
            if (active_q == 8'(k)) begin
               io_out = proj_do[k*IO_W +: IO_W];
               io_oeb = proj_oeb[k*IO_W +: IO_W];
            end
         end
      end
   end

   assign wbs_ack_o       = ack_q;
   assign wbs_dat_o       = dat_q;
   assign rst_n_o         = rst_n_q;
   assign custom_settings = settings_q;
   assign irq             = {1'b0, inval_q, done_q};

endmodule

// File: tb/tb_proj_mux_ctrl.sv
// Self-checking bench for proj_mux_ctrl against a behavioural register/pad model.
module tb_proj_mux_ctrl;

   localparam int          NPROJ    = 5;
   localparam int          IO_W     = 33;
   localparam int          RST_HOLD = 16;
   localparam logic [31:0] BASE     = 32'h3000_0000;
   localparam int          PW       = NPROJ * IO_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]        sel = 4'h0;
   logic [31:0]       adr = '0, dat = '0;
   logic              ack;
   logic [31:0]       dat_o;
   logic [PW-1:0]     proj_do = '0, proj_oeb = '0;
   logic [IO_W-1:0]   io_out, io_oeb;
   logic [NPROJ-1:0]  rst_n_o;
   logic [31:0]       custom_settings;
   logic [2:0]        irq;

   int n_tests = 0;
   int n_fail  = 0;

   int          m_active;
   logic        m_err;
   logic [31:0] m_settings;

   proj_mux_ctrl #(
      .NPROJ(NPROJ), .IO_W(IO_W), .RST_HOLD(RST_HOLD), .BASE_ADDR(BASE)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .proj_do(proj_do), .proj_oeb(proj_oeb),
      .io_out(io_out), .io_oeb(io_oeb), .rst_n_o(rst_n_o),
      .custom_settings(custom_settings), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [NPROJ-1:0] exp_rstn(int s);
      return (s < NPROJ) ? NPROJ'(1 << s) : '0;
   endfunction

   function automatic logic [IO_W-1:0] exp_out(int s);
      return (s < NPROJ) ? IO_W'(proj_do >> (s * IO_W)) : '0;
   endfunction

   function automatic logic [IO_W-1:0] exp_oeb(int s);
      return (s < NPROJ) ? IO_W'(proj_oeb >> (s * IO_W)) : '1;
   endfunction

   function automatic logic [31:0] exp_status();
      return {22'd0, m_err, 1'b0, 8'(m_active)};
   endfunction

   task automatic randomize_pads();
      for (int i = 0; i < PW; i++) begin
         proj_do[i]  = 1'($urandom_range(0, 1));
         proj_oeb[i] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic wait_ack();
      int k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!ack && k < 4);
      if (!ack) begin
         n_tests++; n_fail++;
         $display("FAIL wb_ack_timeout: got ack=%b after %0d cycles required 1", ack, k);
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 1; adr = a; dat = d; sel = s;
      wait_ack();
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
      wait_ack();
      d = dat_o;
      cyc = 0; stb = 0;
   endtask

   task automatic wait_cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      n_tests++; if (rst_n_o !== '0) begin n_fail++; $display("FAIL reset_rst_n: got %b required %b", rst_n_o, 5'b0); end
      n_tests++; if (io_oeb !== '1) begin n_fail++; $display("FAIL reset_io_oeb: got %h required all ones", io_oeb); end
      n_tests++; if (io_out !== '0) begin n_fail++; $display("FAIL reset_io_out: got %h required 0", io_out); end
      n_tests++; if (irq !== 3'b000 || ack !== 1'b0 || dat_o !== '0 || custom_settings !== '0) begin
         n_fail++; $display("FAIL reset_misc: irq=%b ack=%b dat_o=%h settings=%h required all 0", irq, ack, dat_o, custom_settings);
      end
      wb_read(BASE + 32'h4, rd);
      n_tests++; if (rd !== 32'h0000_0005) begin n_fail++; $display("FAIL reset_status: got %h required %h", rd, 32'h5); end
   endtask

   task automatic test_ack();
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4; sel = 4'hF;
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk); #1;
         n_tests++; if (ack !== 1'(n % 2)) begin n_fail++; $display("FAIL ack_pattern[%0d]: got %b required %b", n, ack, 1'(n % 2)); end
      end
      cyc = 0; stb = 0;
   endtask

   task automatic test_select_timing();
      logic [31:0] rd;
      int pulses = 0;
      logic [NPROJ-1:0] want;
      wb_write(BASE, 32'd2, 4'hF);
      for (int n = 1; n <= RST_HOLD + 3; n++) begin
         @(posedge clk); #1;
         want = (n >= RST_HOLD + 2) ? 5'b00100 : 5'b00000;
         n_tests++; if (rst_n_o !== want) begin n_fail++; $display("FAIL sel2_rst_n[cyc %0d]: got %b required %b", n, rst_n_o, want); end
         if (irq[0]) pulses++;
         if (n == RST_HOLD + 2) begin
            n_tests++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL sel2_irq0_timing: got %b required 1", irq[0]); end
         end
      end
      n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL sel2_irq0_count: got %0d required 1", pulses); end
      m_active = 2;
      for (int r = 0; r < 3; r++) begin
         randomize_pads(); #1;
         n_tests++; if (io_out !== exp_out(2) || io_oeb !== exp_oeb(2)) begin
            n_fail++; $display("FAIL sel2_pads: got out=%h oeb=%h required out=%h oeb=%h", io_out, io_oeb, exp_out(2), exp_oeb(2));
         end
      end
      wb_read(BASE, rd);
      n_tests++; if (rd !== 32'd2) begin n_fail++; $display("FAIL ctrl_readback: got %h required %h", rd, 32'd2); end
      wb_read(BASE + 32'h4, rd);
      n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL sel2_status: got %h required %h", rd, exp_status()); end
   endtask

   task automatic test_switch_to_zero();
      wb_write(BASE, 32'd0, 4'hF);
      wait_cycles(RST_HOLD / 2);
      n_tests++; if (rst_n_o !== '0 || io_oeb !== '1 || io_out !== '0) begin
         n_fail++; $display("FAIL drain_outputs: got rst_n=%b oeb=%h out=%h required 0/all ones/0", rst_n_o, io_oeb, io_out);
      end
      wait_cycles(RST_HOLD);
      m_active = 0;
      n_tests++; if (rst_n_o !== 5'b00001) begin n_fail++; $display("FAIL sel0_rst_n: got %b required %b", rst_n_o, 5'b00001); end
      n_tests++; if (io_out !== exp_out(0) || io_oeb !== exp_oeb(0)) begin
         n_fail++; $display("FAIL sel0_pads: got out=%h oeb=%h required out=%h oeb=%h", io_out, io_oeb, exp_out(0), exp_oeb(0));
      end
   endtask

   task automatic test_invalid();
      logic [31:0] rd;
      logic [31:0] bad [2];
      bad[0] = 32'd9;
      bad[1] = 32'($urandom_range(NPROJ + 1, 255));
      foreach (bad[i]) begin
         wb_write(BASE, bad[i], 4'hF);
         m_err = 1'b1;
         n_tests++; if (irq[1] !== 1'b1) begin n_fail++; $display("FAIL invalid_irq1[%0d]: got %b required 1", bad[i], irq[1]); end
         @(posedge clk); #1;
         n_tests++; if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL invalid_irq1_width: got %b required 0", irq[1]); end
         wb_read(BASE + 32'h4, rd);
         n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL invalid_status: got %h required %h", rd, exp_status()); end
      end
      wait_cycles(RST_HOLD + 4);
      n_tests++; if (rst_n_o !== exp_rstn(m_active)) begin n_fail++; $display("FAIL invalid_no_switch: got %b required %b", rst_n_o, exp_rstn(m_active)); end
      wb_write(BASE + 32'h4, 32'h0000_0200, 4'hF);
      m_err = 1'b0;
      wb_read(BASE + 32'h4, rd);
      n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL err_clear: got %h required %h", rd, exp_status()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int pulses = 0;
      wb_write(BASE, 32'd1, 4'hF);
      wait_cycles(3);
      wb_write(BASE, 32'd3, 4'hF);
      for (int n = 0; n < 2 * RST_HOLD + 8; n++) begin
         @(posedge clk); #1;
         if (irq[0]) pulses++;
      end
      m_active = 3;
      n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL b2b_irq0_count: got %0d required 1", pulses); end
      n_tests++; if (rst_n_o !== 5'b01000) begin n_fail++; $display("FAIL b2b_rst_n: got %b required %b", rst_n_o, 5'b01000); end
      wb_read(BASE + 32'h4, rd);
      n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL b2b_status: got %h required %h", rd, exp_status()); end
   endtask

   task automatic test_soft_rst();
      int pulses = 0;
      wb_write(BASE + 32'hC, $urandom, 4'hF);
      for (int n = 1; n <= RST_HOLD + 3; n++) begin
         @(posedge clk); #1;
         if (irq[0]) pulses++;
         if (n == RST_HOLD / 2) begin
            n_tests++; if (rst_n_o !== '0) begin n_fail++; $display("FAIL soft_rst_drain: got %b required 0", rst_n_o); end
         end
      end
      n_tests++; if (rst_n_o !== exp_rstn(m_active) || pulses != 1) begin
         n_fail++; $display("FAIL soft_rst_release: got rst_n=%b pulses=%0d required %b and 1", rst_n_o, pulses, exp_rstn(m_active));
      end
   endtask

   task automatic test_out_of_window();
      logic [31:0] rd;
      wb_write(BASE + 32'h10, 32'd1, 4'hF);
      wb_read(BASE + 32'h14, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oow_read: got %h required 0", rd); end
      wait_cycles(RST_HOLD + 4);
      n_tests++; if (rst_n_o !== exp_rstn(m_active)) begin n_fail++; $display("FAIL oow_write_dropped: got %b required %b", rst_n_o, exp_rstn(m_active)); end
   endtask

   task automatic test_random();
      logic [31:0] rd;
      int s;
      for (int it = 0; it < 8; it++) begin
         s = $urandom_range(0, NPROJ);
         randomize_pads();
         wb_write(BASE, 32'(s), 4'hF);
         wait_cycles(RST_HOLD + 4);
         m_active = s;
         n_tests++; if (rst_n_o !== exp_rstn(s)) begin n_fail++; $display("FAIL rand_rst_n[sel %0d]: got %b required %b", s, rst_n_o, exp_rstn(s)); end
         randomize_pads(); #1;
         n_tests++; if (io_out !== exp_out(s) || io_oeb !== exp_oeb(s)) begin
            n_fail++; $display("FAIL rand_pads[sel %0d]: got out=%h oeb=%h required out=%h oeb=%h", s, io_out, io_oeb, exp_out(s), exp_oeb(s));
         end
         wb_read(BASE + 32'h4, rd);
         n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL rand_status[sel %0d]: got %h required %h", s, rd, exp_status()); end
      end
   endtask

   task automatic test_reset_mid_drain();
      logic [31:0] rd;
      wb_write(BASE + 32'h8, 32'h1234_5678, 4'hF);
      wb_write(BASE, 32'd4, 4'hF);
      wait_cycles(5);
      #2 rst = 1'b1;
      #1;
      n_tests++; if (custom_settings !== '0 || rst_n_o !== '0 || io_oeb !== '1 || io_out !== '0 || irq !== '0 || ack !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_outputs: got settings=%h rst_n=%b oeb=%h out=%h irq=%b ack=%b required reset values",
                            custom_settings, rst_n_o, io_oeb, io_out, irq, ack);
      end
      @(negedge clk); rst = 1'b0;
      m_active = NPROJ; m_err = 1'b0; m_settings = '0;
      wait_cycles(RST_HOLD + 4);
      n_tests++; if (rst_n_o !== '0) begin n_fail++; $display("FAIL reset_discards_pending: got %b required 0", rst_n_o); end
      wb_read(BASE + 32'h4, rd);
      n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL post_reset_status: got %h required %h", rd, exp_status()); end
   endtask

   task automatic test_settings();
      logic [31:0] rd, d;
      logic [3:0]  s;
      for (int it = 0; it < 4; it++) begin
         if (it == 0) begin d = 32'hAABB_CCDD; s = 4'b0010; end
         else begin d = $urandom; s = 4'($urandom_range(0, 15)); end
         wb_write(BASE + 32'h8, d, s);
         for (int b = 0; b < 4; b++) if (s[b]) m_settings[8*b +: 8] = d[8*b +: 8];
         wb_read(BASE + 32'h8, rd);
         n_tests++; if (rd !== m_settings || custom_settings !== m_settings) begin
            n_fail++; $display("FAIL settings[sel %b]: got read=%h port=%h required %h", s, rd, custom_settings, m_settings);
         end
      end
   endtask

   initial begin
      m_active = NPROJ; m_err = 1'b0; m_settings = '0;
      randomize_pads();
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      wait_cycles(1);
      test_reset();
      test_ack();
      test_select_timing();
      test_switch_to_zero();
      test_invalid();
      test_back_to_back();
      test_soft_rst();
      test_out_of_window();
      test_random();
      test_reset_mid_drain();
      test_settings();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/proj_mux_ctrl.md
# proj_mux_ctrl

Parametrised project-select controller for the multi-project user area. Owns the Wishbone register file that chooses which of `NPROJ` hosted designs drives the shared IO pads. Sequences every selection change safely: all projects held in reset, pads tri-stated, selection switched, then only the chosen project released. Also exports the shared `custom_settings` word and completion/error interrupts.

## Interface
Parameters:
- `NPROJ`, 5, number of hosted projects (1–254).
- `IO_W`, 33, shared pad width per project.
- `RST_HOLD`, 16, cycles all resets stay asserted during a switch (≥1).
- `BASE_ADDR`, 32'h3000_0000, Wishbone base; decode on `adr[31:4]`.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  Wishbone strobes.
- `wbs_sel_i`  in  4  byte lanes; only honoured on SETTINGS.
- `wbs_adr_i`, `wbs_dat_i`  in  32  address / write data.
- `wbs_ack_o`  out  1  single-cycle ack.
- `wbs_dat_o`  out  32  read data.
- `proj_do`  in  NPROJ*IO_W  flattened project outputs; slice k = project k.
- `proj_oeb`  in  NPROJ*IO_W  flattened project output-enables (active-low).
- `io_out`  out  IO_W  muxed pad data.
- `io_oeb`  out  IO_W  muxed pad OE (1 = input).
- `rst_n_o`  out  NPROJ  per-project active-low reset.
- `custom_settings`  out  32  shared configuration word.
- `irq`  out  3  [0] switch-done pulse, [1] invalid-select pulse, [2] tied 0.

## Operation
- Registers (`adr[3:2]`): 0 CTRL W: `[7:0]` requested select; R: last request. 1 STATUS R: `[7:0]` active select, `[8]` busy, `[9]` sticky error (write 1 clears). 2 SETTINGS RW, byte-masked. 3 SOFT_RST W: any write re-runs the sequence on the current selection.
- Select value `NPROJ` = "none": all resets held, pads all inputs. Values > `NPROJ`: ignored, error bit set, `irq[1]` pulse.
- Addresses outside `BASE_ADDR`'s 16-byte window: still acked, reads return 0, writes dropped.
- FSM states IDLE, DRAIN, SWITCH, RELEASE.
  - IDLE: if `pend_v` → DRAIN.
  - DRAIN: `rst_n_o` = all 0, `out_en` = 0; count `RST_HOLD` cycles → SWITCH.
  - SWITCH: `active` ← `pend_sel`, clear `pend_v` → RELEASE.
  - RELEASE: `rst_n_o[active]` ← 1 (none if `active==NPROJ`), `out_en` ← 1, `irq[0]` pulse → IDLE.
- Valid CTRL/SOFT_RST writes load `pend_sel`/`pend_v` in any state. Writes during busy overwrite the pending value (last wins). If `pend_v` is set again before SWITCH, the newest value is used. If set after SWITCH, one further full sequence follows.
- Pad mux (combinational): `io_out = out_en ? proj_do[active] : 0`; `io_oeb = out_en ? proj_oeb[active] : all 1`. When `active==NPROJ`: `io_oeb` = all 1 and `io_out` = 0 regardless of `out_en`.

## Timing
- Reset values: `active = NPROJ`, `rst_n_o = 0`, `out_en = 0`, `io_oeb` = all 1, `io_out = 0`, `ack = 0`, `dat_o = 0`, `custom_settings = 0`, `irq = 0`, state IDLE, `pend_v = 0`.
- `ack` registered: high exactly one cycle after `cyc&stb`, then low for at least one cycle. No back-to-back acks. `dat_o` is valid with `ack`.
- Write acked at edge E0. DRAIN entered at E1. SWITCH at E1+RST_HOLD. Selected `rst_n_o` high and `irq[0]` pulse at E1+RST_HOLD+1 (visible the following cycle).
- `wb_rst_i` mid-sequence: asynchronous return to reset values. The pending request is discarded.

## Structure
- Package `proj_mux_pkg`: FSM state enum, register offset constants, STATUS bit indices.
- No sub-modules; the pad mux is an indexed part-select inside this module.

## Test plan
- Reset, then read STATUS → 0x0000_0005 (NPROJ=5). `io_oeb` all 1, `rst_n_o` = 0.
- Write CTRL=2 → `rst_n_o` = 5'b00100 exactly RST_HOLD+2 cycles after ack. `io_out` tracks `proj_do` slice 2. `irq[0]` high for 1 cycle.
- From active 2, write CTRL=0 → during DRAIN `rst_n_o` = 0 and `io_oeb` all 1. Then `rst_n_o` = 5'b00001.
- Write CTRL=9 → STATUS[9]=1, `irq[1]` pulse, active unchanged. Writing STATUS bit 9 = 1 clears it.
- While busy, write CTRL=1 then CTRL=3 before SWITCH → final active = 3, only one `irq[0]` pulse.
- Assert `wb_rst_i` mid-DRAIN → all outputs return to reset values immediately. SETTINGS byte-masked write (sel=4'b0010, data 0xAABBCCDD) reads back 0x0000CC00.
